// File: rtl/tt_ranrx_pkg.sv
// Shared types and constants for the TRNG word receiver.
package tt_ranrx_pkg;

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_FAIL    = 1'b1
   } rx_state_e;

   localparam int unsigned WORD_W_DEF     = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned RCT_CUTOFF_DEF = 16;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/tt_ranrx_fifo.sv
// Synchronous word FIFO with a registered head output; accepts push while full
// when a pop happens on the same edge.
module tt_ranrx_fifo
   import tt_ranrx_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WORD_W-1:0]        i_din,
   output logic [WORD_W-1:0]        o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [cnt_w(DEPTH)-1:0]  o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [CW-1:0]     r_count;
   logic [WORD_W-1:0] r_dout;
   logic              w_pop;
   logic              w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_dout  = r_dout;
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);

   // Head register tracks whichever entry will be at the read pointer next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_dout  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push && o_empty)
            r_dout <= i_din;
         else if (w_pop && (r_count > CW'(1)))
            r_dout <= r_mem[r_rd + AW'(1)];
         else if (w_pop && w_push)
            r_dout <= i_din;
      end
   end

endmodule

// File: rtl/tt_ranword_rx.sv
// TRNG bit-stream receiver: packs bits MSB-first into words, queues them in a FIFO.
// Define TT_RANRX_HEALTH_EN to enable the repetition-count health test.
module tt_ranword_rx
   import tt_ranrx_pkg::*;
#(
   parameter int unsigned WORD_W     = WORD_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          bit_in,
   input  logic                          bit_valid,
   output logic [WORD_W-1:0]             word_out,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [cnt_w(FIFO_DEPTH)-1:0]  fifo_count,
   output logic                          overflow,
   output logic                          rct_fail,
   input  logic                          clear_flags
);

   localparam int unsigned BW = $clog2(WORD_W);

   rx_state_e         r_state;
   logic [WORD_W-2:0] r_asm;
   logic [BW-1:0]     r_bitcnt;
   logic              r_overflow;
   logic              w_accept;
   logic              w_last;
   logic              w_trip;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [WORD_W-1:0] w_word;

   assign w_accept   = bit_valid & (r_state == ST_COLLECT) & ~clear_flags;
   assign w_last     = (r_bitcnt == BW'(WORD_W - 1));
   assign w_word     = {r_asm, bit_in};
   assign w_pop      = word_ready & ~w_empty;
   assign w_push     = w_accept & w_last & ~w_trip;
   assign word_valid = ~w_empty;
   assign overflow   = r_overflow;

`ifdef TT_RANRX_HEALTH_EN
   localparam int unsigned RUN_W = 8;

   logic [RUN_W-1:0] r_run;
   logic             r_prev;
   logic             r_rct_fail;
   logic [RUN_W-1:0] w_run_nxt;

   assign w_run_nxt = ((r_run != '0) && (bit_in == r_prev)) ? r_run + RUN_W'(1) : RUN_W'(1);
   assign w_trip    = w_accept & (w_run_nxt == RUN_W'(RCT_CUTOFF));
   assign rct_fail  = r_rct_fail;

   // Repetition-count run tracker; the run spans word boundaries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run      <= '0;
         r_prev     <= 1'b0;
         r_rct_fail <= 1'b0;
      end else if (clear_flags) begin
         r_run      <= '0;
         r_rct_fail <= 1'b0;
      end else if (w_accept) begin
         r_run  <= w_run_nxt;
         r_prev <= bit_in;
         if (w_trip) r_rct_fail <= 1'b1;
      end
   end
`else
   assign w_trip   = 1'b0;
   assign rct_fail = 1'b0;

   // Cutoff only matters with the health test; keep it referenced as a range guard.
   if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_cutoff_out_of_range
   end
`endif

   // Packing FSM: assembly register, bit counter, overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_COLLECT;
         r_asm      <= '0;
         r_bitcnt   <= '0;
         r_overflow <= 1'b0;
      end else if (clear_flags) begin
         r_state    <= ST_COLLECT;
         r_asm      <= '0;
         r_bitcnt   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
         case (r_state)
            ST_COLLECT: begin
               if (w_accept) begin
                  if (w_trip) begin
                     r_state  <= ST_FAIL;
                     r_asm    <= '0;
                     r_bitcnt <= '0;
                  end else begin
                     r_asm    <= w_word[WORD_W-2:0];
                     r_bitcnt <= w_last ? '0 : r_bitcnt + BW'(1);
                  end
               end
            end
            ST_FAIL: r_state <= ST_FAIL;
            default: r_state <= ST_COLLECT;
         endcase
      end
   end

   tt_ranrx_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (word_ready),
      .i_din   (w_word),
      .o_dout  (word_out),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

endmodule

// File: tb/tb_tt_ranword_rx.sv
// Scoreboard bench for tt_ranword_rx: expected words queued at stimulus time,
// a negedge monitor compares every accepted word.
module tb_tt_ranword_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_in;
   logic       bit_valid;
   logic [7:0] word_out;
   logic       word_valid;
   logic       word_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       rct_fail;
   logic       clear_flags;

   logic [7:0] sb_q [$];
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   tt_ranword_rx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .rct_fail    (rct_fail),
      .clear_flags (clear_flags)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a word is consumed on the next edge when valid&ready.
   always @(negedge clk) begin
      if (rst_n && word_valid && word_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected none", word_out);
         end else begin
            logic [7:0] e;
            e = sb_q.pop_front();
            check("word_out", {24'h0, word_out}, {24'h0, e});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_in    = b;
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit kept);
      if (kept) sb_q.push_back(w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_clear();
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
   endtask

   task automatic drain();
      word_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (fifo_count == 3'd0) break;
      end
      word_ready = 1'b0;
      check("drain_count", {29'h0, fifo_count}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_word_out"},   {24'h0, word_out},   32'h0);
      check({tag, "_word_valid"}, {31'h0, word_valid}, 32'h0);
      check({tag, "_fifo_count"}, {29'h0, fifo_count}, 32'h0);
      check({tag, "_overflow"},   {31'h0, overflow},   32'h0);
      check({tag, "_rct_fail"},   {31'h0, rct_fail},   32'h0);
   endtask

   initial begin
      logic [7:0] w;
      rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
      word_ready = 1'b0; clear_flags = 1'b0;
      tick(); tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Basic packing: 1,0,1,1,0,0,1,0 -> B2, visible right after the 8th edge
      word_ready = 1'b1;
      send_word(8'hB2, 1'b1);
      check("lat_valid", {31'h0, word_valid}, 32'd1);
      check("lat_word",  {24'h0, word_out},   32'hB2);
      tick();
      check("pop_count", {29'h0, fifo_count}, 32'd0);
      word_ready = 1'b0;

      // Fill FIFO with ready low; fifth word is dropped
      send_word(8'h55, 1'b1);
      send_word(8'hAA, 1'b1);
      send_word(8'h55, 1'b1);
      send_word(8'hAA, 1'b1);
      check("full_count", {29'h0, fifo_count}, 32'd4);
      check("full_ovf",   {31'h0, overflow},   32'd0);
      send_word(8'h55, 1'b0);
      check("ovf_count", {29'h0, fifo_count}, 32'd4);
      check("ovf_set",   {31'h0, overflow},   32'd1);
      drain();
      pulse_clear();
      check("ovf_clear", {31'h0, overflow}, 32'd0);

      // Full FIFO with pop and last bit on the same edge: push accepted
      send_word(8'h01, 1'b1);
      send_word(8'h02, 1'b1);
      send_word(8'h03, 1'b1);
      send_word(8'h04, 1'b1);
      w = 8'hC3;
      sb_q.push_back(w);
      for (int i = 7; i >= 1; i--) send_bit(w[i]);
      word_ready = 1'b1;
      send_bit(w[0]);
      word_ready = 1'b0;
      check("sim_ovf",   {31'h0, overflow},   32'd0);
      check("sim_count", {29'h0, fifo_count}, 32'd4);
      drain();

`ifdef TT_RANRX_HEALTH_EN
      // 16 identical bits trip the health test; the second word is never pushed
      pulse_clear();
      word_ready = 1'b1;
      sb_q.push_back(8'hFF);
      for (int i = 0; i < 16; i++) send_bit(1'b1);
      check("rct_set", {31'h0, rct_fail}, 32'd1);
      tick();
      send_word(8'hA5, 1'b0);
      check("fail_ignored_cnt", {29'h0, fifo_count}, 32'd0);
      check("fail_ignored_vld", {31'h0, word_valid}, 32'd0);
      pulse_clear();
      check("rct_clear", {31'h0, rct_fail}, 32'd0);
      send_word(8'h96, 1'b1);
      tick();
      word_ready = 1'b0;
`else
      // Without the health test a long run of zeros is just data
      word_ready = 1'b1;
      for (int k = 0; k < 8; k++) send_word(8'h00, 1'b1);
      tick();
      check("no_rct", {31'h0, rct_fail}, 32'd0);
      word_ready = 1'b0;
`endif
      check("sb_empty_mid", sb_q.size(), 32'd0);

      // Reset mid-word with two words queued: all state lost
      send_word(8'h11, 1'b0);
      send_word(8'h22, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      rst_n = 1'b0;
      tick();
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      send_word(8'h7E, 1'b1);
      check("post_rst_count", {29'h0, fifo_count}, 32'd1);
      drain();
      tick();

      check("sb_empty_end", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tt_ranword_rx.md
# tt_ranword_rx

Receiving end of the TRNG serial bit stream. Consumes one conditioned random bit per strobe, runs an optional repetition-count health test, packs bits into WORD_W-bit words and hands them to a downstream consumer over a valid/ready handshake through a small FIFO. It sits after the XOR of the ring-oscillator/LFSR stream and replaces ad-hoc 4-bit sampling with a lossless, flow-controlled word interface.

## Interface
Parameters:
- WORD_W, 8, bits per output word (2..16)
- FIFO_DEPTH, 4, word FIFO entries (power of two, 2..16)
- RCT_CUTOFF, 16, run length of identical bits that declares a health failure (2..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- bit_in  in  1  random bit, sampled when bit_valid=1
- bit_valid  in  1  bit strobe, one bit per cycle max
- word_out  out  WORD_W  head-of-FIFO word
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts word_out when word_valid&word_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words held
- overflow  out  1  sticky: completed word dropped because FIFO full
- rct_fail  out  1  sticky: health test tripped
- clear_flags  in  1  clears overflow and rct_fail, restarts assembly

## Operation
- FSM states: COLLECT, FAIL. Reset -> COLLECT.
- COLLECT: on bit_valid, shift bit_in into assembly register MSB-first (first bit of a word ends at word_out[WORD_W-1]); bit counter increments 0..WORD_W-1, wraps to 0 on the last bit.
- Last bit accepted: completed word pushed to FIFO same edge. If FIFO full and no pop that cycle: word dropped, overflow<=1. Full with simultaneous pop: push accepted.
- Health test: run counter tracks consecutive identical accepted bits (first bit after reset/clear gives run=1). When run reaches RCT_CUTOFF: rct_fail<=1, FSM -> FAIL, partial word discarded, bit counter <=0; the failing bit's word is never pushed.
- FAIL: bits ignored; FIFO still drains normally.
- clear_flags (priority over bit_valid same cycle): overflow<=0, rct_fail<=0, run counter<=0, bit counter<=0, assembly discarded, FSM -> COLLECT. FIFO contents kept.
- Pop: word_valid&word_ready advances FIFO read pointer; word_ready while empty has no effect.
- Pointers wrap modulo FIFO_DEPTH; fifo_count = writes - reads, 0..FIFO_DEPTH.

## Timing
- Reset values: word_out=0, word_valid=0, fifo_count=0, overflow=0, rct_fail=0; FIFO, counters, assembly cleared.
- Latency: last bit accepted at edge N -> word_valid=1 and word_out valid after edge N (visible cycle N+1) when FIFO was empty.
- word_out is registered read of head entry; changes only on the edge following a pop or a push into an empty FIFO.
- rct_fail asserts the cycle after the bit completing the run; overflow the cycle after the dropped push.
- Reset asserted mid-word or mid-handshake: everything returns to reset values next edge; partial word lost.
- Max throughput: one word per WORD_W bit_valid cycles; consumer may pop every cycle.

## Configuration
- TT_RANRX_HEALTH_EN defined: repetition-count test, FAIL state and rct_fail behave as above.
- Undefined: no run counter; FSM stays in COLLECT; rct_fail tied 0; clear_flags clears only overflow and restarts assembly.

## Structure
- Package tt_ranrx_pkg: FSM state enum (ST_COLLECT, ST_FAIL), default parameter constants, count-width function.
- One sub-module: tt_ranrx_fifo (synchronous FIFO, push/pop/full/empty/count, simultaneous push-pop when full). Packing, health test and FSM stay in tt_ranword_rx.

## Test plan
- Reset, then 8 bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hB2, word_valid high one cycle after 8th bit, fifo_count returns 0.
- word_ready=0, feed 5 words (alternating 8'h55/8'hAA patterns) -> fifo_count=4, overflow=1 after 5th word; popping yields first four words in order.
- FIFO full, pop and last bit of new word same cycle -> no overflow, fifo_count stays 4.
- With TT_RANRX_HEALTH_EN, 16 consecutive 1s -> rct_fail=1 after 16th bit, no word pushed, further bits ignored; clear_flags -> rct_fail=0, next 8 bits form a fresh word.
- Without macro, 64 consecutive 0s -> rct_fail stays 0, eight 8'h00 words delivered.
- rst_n low after 3 bits of a word with 2 words queued -> all outputs reset values; next 8 bits form a complete new word.
